johnson_phase_tracker: RTL and testbench

Downstream monitor for the 4-bit twisted-ring (Johnson) counter. Each cycle it samples the counter's state and decodes it to a 3-bit phase and a one-hot phase vector. It flags illegal codes and out-of-order steps, acquires and holds a lock on a clean sequence, and counts completed revolutions. Consumers use it to derive phase strobes and to detect a corrupted ring, for example a ring sitting in the complementary illegal loop.

---
 rtl/johnson_pkg.sv | 54 +++++
 rtl/johnson_decode.sv | 20 ++
 rtl/johnson_phase_tracker.sv | 132 +++++++++++++
 tb/tb_johnson_phase_tracker.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/johnson_pkg.sv
// Shared types and constants for consumers of the 4-bit Johnson ring.
// Holds the legal code table, FSM/step enums and the step classifier.
package johnson_pkg;

  localparam int unsigned CODE_W     = 4;
  localparam int unsigned PHASE_W    = 3;
  localparam int unsigned NUM_PHASES = 8;
  localparam int unsigned ACQ_W      = 4;

  localparam logic [CODE_W-1:0] CODE_P0 = 4'b0000;
  localparam logic [CODE_W-1:0] CODE_P1 = 4'b1000;
  localparam logic [CODE_W-1:0] CODE_P2 = 4'b1100;
  localparam logic [CODE_W-1:0] CODE_P3 = 4'b1110;
  localparam logic [CODE_W-1:0] CODE_P4 = 4'b1111;
  localparam logic [CODE_W-1:0] CODE_P5 = 4'b0111;
  localparam logic [CODE_W-1:0] CODE_P6 = 4'b0011;
  localparam logic [CODE_W-1:0] CODE_P7 = 4'b0001;

  // Indexed by phase: LEGAL_CODES[p] is the ring state for phase p.
  localparam logic [NUM_PHASES-1:0][CODE_W-1:0] LEGAL_CODES = {
    CODE_P7, CODE_P6, CODE_P5, CODE_P4, CODE_P3, CODE_P2, CODE_P1, CODE_P0
  };

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    ILLEGAL = 2'd0,
    HOLD    = 2'd1,
    ADV     = 2'd2,
    SKIP    = 2'd3
  } step_e;

  typedef struct packed {
    logic               legal;
    logic [PHASE_W-1:0] phase;
  } decode_t;

  function automatic logic [NUM_PHASES-1:0] phase_onehot(input logic [PHASE_W-1:0] p);
    return NUM_PHASES'(1) << p;
  endfunction

  // Relation of a decoded sample to the previously stored phase.
  function automatic step_e classify(input decode_t d, input logic [PHASE_W-1:0] prev);
    if (!d.legal) return ILLEGAL;
    if (d.phase == prev) return HOLD;
    if (d.phase == PHASE_W'(prev + PHASE_W'(1))) return ADV;
    return SKIP;
  endfunction

endpackage

// File: rtl/johnson_decode.sv
// Combinational Johnson-code decoder: ring state to {legal, phase}.
// Shared by any consumer of the ring; no state.
module johnson_decode
  import johnson_pkg::*;
(
  input  logic [CODE_W-1:0] q,
  output decode_t           dec
);

  always_comb begin
    dec = '0;
    for (int i = 0; i < int'(NUM_PHASES); i++) begin
      if (q == LEGAL_CODES[i]) begin
        dec.legal = 1'b1;
        dec.phase = PHASE_W'(i);
      end
    end
  end

endmodule

// File: rtl/johnson_phase_tracker.sv
// Monitors a Johnson ring: decodes phase, flags illegal/out-of-order steps,
// acquires and holds lock, and counts revolutions while locked.
module johnson_phase_tracker
  import johnson_pkg::*;
#(
  parameter int unsigned LOCK_N = 4,
  parameter int unsigned REV_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CODE_W-1:0]     q,
  output logic [PHASE_W-1:0]    phase,
  output logic [NUM_PHASES-1:0] phase_oh,
  output logic                  valid,
  output logic                  err,
  output logic                  seq_err,
  output logic                  locked,
  output logic                  rev_pulse,
  output logic [REV_W-1:0]      rev_cnt
);

  decode_t                 dec;
  step_e                   step;
  state_e                  state;
  state_e                  state_next;
  logic [ACQ_W-1:0]        acq_cnt;
  logic [ACQ_W-1:0]        acq_cnt_next;
  logic [ACQ_W-1:0]        acq_inc;
  logic [PHASE_W-1:0]      prev;
  logic [PHASE_W-1:0]      prev_next;
  logic [NUM_PHASES-1:0]   phase_oh_next;
  logic                    valid_next;
  logic                    err_next;
  logic                    seq_err_next;
  logic                    locked_next;
  logic                    rev_pulse_next;
  logic [REV_W-1:0]        rev_cnt_next;

  johnson_decode u_decode (
    .q   (q),
    .dec (dec)
  );

  assign step    = classify(dec, prev);
  assign acq_inc = ACQ_W'(acq_cnt + ACQ_W'(1));

  // The stored phase doubles as the reference for step classification.
  assign phase = prev;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= UNLOCKED;
      acq_cnt <= '0;
    end else begin
      state   <= state_next;
      acq_cnt <= acq_cnt_next;
    end
  end

  always_comb begin
    state_next   = state;
    acq_cnt_next = acq_cnt;
    case (state)
      UNLOCKED: begin
        if (dec.legal) begin
          state_next   = ACQUIRE;
          acq_cnt_next = '0;
        end
      end
      ACQUIRE: begin
        case (step)
          ADV: begin
            acq_cnt_next = acq_inc;
            if (acq_inc == ACQ_W'(LOCK_N)) state_next = LOCKED;
          end
          SKIP:    acq_cnt_next = '0;
          ILLEGAL: begin
            state_next   = UNLOCKED;
            acq_cnt_next = '0;
          end
          default: ;
        endcase
      end
      LOCKED: begin
        if (step == SKIP || step == ILLEGAL) begin
          state_next   = UNLOCKED;
          acq_cnt_next = '0;
        end
      end
      default: begin
        state_next   = UNLOCKED;
        acq_cnt_next = '0;
      end
    endcase
  end

  // Next values of the registered outputs; a revolution counts only when
  // already LOCKED, so the advance that completes lock never counts.
  always_comb begin
    prev_next      = dec.legal ? dec.phase : prev;
    valid_next     = dec.legal;
    phase_oh_next  = dec.legal ? phase_onehot(dec.phase) : '0;
    err_next       = !dec.legal;
    seq_err_next   = (step == SKIP) && (state != UNLOCKED);
    locked_next    = (state_next == LOCKED);
    rev_pulse_next = (state == LOCKED) && (step == ADV) && (prev == PHASE_W'(NUM_PHASES - 1));
    rev_cnt_next   = REV_W'(rev_cnt + REV_W'(rev_pulse_next));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      prev      <= '0;
      phase_oh  <= '0;
      valid     <= 1'b0;
      err       <= 1'b0;
      seq_err   <= 1'b0;
      locked    <= 1'b0;
      rev_pulse <= 1'b0;
      rev_cnt   <= '0;
    end else begin
      prev      <= prev_next;
      phase_oh  <= phase_oh_next;
      valid     <= valid_next;
      err       <= err_next;
      seq_err   <= seq_err_next;
      locked    <= locked_next;
      rev_pulse <= rev_pulse_next;
      rev_cnt   <= rev_cnt_next;
    end
  end

endmodule

// File: tb/tb_johnson_phase_tracker.sv
// Self-checking bench for johnson_phase_tracker against a phase-arithmetic model.
// A second instance with REV_W=2 shares the stimulus to exercise counter wrap.
module tb_johnson_phase_tracker;

  localparam int LOCK_N = 4;
  localparam logic [3:0] RING [8] = '{4'b0000, 4'b1000, 4'b1100, 4'b1110,
                                      4'b1111, 4'b0111, 4'b0011, 4'b0001};

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] q;

  logic [2:0] phase, phase2;
  logic [7:0] phase_oh, phase_oh2;
  logic       valid, err, seq_err, locked, rev_pulse;
  logic       valid2, err2, seq_err2, locked2, rev_pulse2;
  logic [7:0] rev_cnt;
  logic [1:0] rev_cnt2;

  int checks   = 0;
  int failures = 0;

  // Reference model: mode 0 = unlocked, 1 = acquiring, 2 = locked.
  int m_mode, m_run, m_prev, m_rev;
  bit m_valid, m_err, m_seq, m_revp;

  johnson_phase_tracker #(.LOCK_N(LOCK_N), .REV_W(8)) dut (
    .clk(clk), .rst(rst), .q(q), .phase(phase), .phase_oh(phase_oh),
    .valid(valid), .err(err), .seq_err(seq_err), .locked(locked),
    .rev_pulse(rev_pulse), .rev_cnt(rev_cnt)
  );

  johnson_phase_tracker #(.LOCK_N(LOCK_N), .REV_W(2)) dut2 (
    .clk(clk), .rst(rst), .q(q), .phase(phase2), .phase_oh(phase_oh2),
    .valid(valid2), .err(err2), .seq_err(seq_err2), .locked(locked2),
    .rev_pulse(rev_pulse2), .rev_cnt(rev_cnt2)
  );

  initial forever #5 clk = ~clk;

  function automatic int lookup(input logic [3:0] c);
    for (int i = 0; i < 8; i++) if (RING[i] == c) return i;
    return -1;
  endfunction

  function automatic logic [23:0] exp_vec();
    logic [7:0] oh;
    oh = m_valid ? (8'(1) << m_prev) : 8'h00;
    return {3'(m_prev), oh, m_valid, m_err, m_seq, (m_mode == 2), m_revp, 8'(m_rev)};
  endfunction

  function automatic logic [23:0] got_vec();
    return {phase, phase_oh, valid, err, seq_err, locked, rev_pulse, rev_cnt};
  endfunction

  // Apply one sample (rv=0 means reset at this edge), update model, wait past the edge.
  task automatic drive(input logic [3:0] qv, input logic rv);
    int idx, d;
    q   = qv;
    rst = rv;
    if (!rv) begin
      m_mode = 0; m_run = 0; m_prev = 0; m_rev = 0;
      m_valid = 0; m_err = 0; m_seq = 0; m_revp = 0;
    end else begin
      idx    = lookup(qv);
      m_err  = (idx < 0);
      m_seq  = 0;
      m_revp = 0;
      if (idx < 0) begin
        m_valid = 0;
        m_mode  = 0;
      end else begin
        m_valid = 1;
        d = (idx - m_prev + 8) % 8;
        case (m_mode)
          0: begin m_mode = 1; m_run = 0; end
          1: begin
            if (d == 1) begin
              m_run++;
              if (m_run == LOCK_N) m_mode = 2;
            end else if (d != 0) begin
              m_run = 0; m_seq = 1;
            end
          end
          default: begin
            if (d == 1 && idx == 0) begin
              m_revp = 1; m_rev++;
            end else if (d > 1) begin
              m_mode = 0; m_seq = 1;
            end
          end
        endcase
        m_prev = idx;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive_phase(input int p);
    drive(RING[p % 8], 1'b1);
  endtask

  task automatic test_reset();
    drive(4'b0101, 1'b0);
    checks++;
    if (got_vec() !== 24'h0) begin
      failures++;
      $display("FAIL reset_outputs got=%h want=000000", got_vec());
    end
    checks++;
    if ({phase_oh2, valid2, locked2, rev_cnt2} !== 12'h0) begin
      failures++;
      $display("FAIL reset_outputs_w2 got=%h want=000", {phase_oh2, valid2, locked2, rev_cnt2});
    end
  endtask

  task automatic test_illegal_stuck();
    drive(4'b0000, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive(4'b1011, 1'b1);
      checks++;
      if ({err, valid, locked, seq_err, phase_oh, phase} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0}) begin
        failures++;
        $display("FAIL illegal_stuck cyc=%0d err=%b valid=%b locked=%b seq_err=%b oh=%h phase=%0d want err=1 rest 0",
                 i, err, valid, locked, seq_err, phase_oh, phase);
      end
    end
  endtask

  task automatic test_acquire();
    drive(4'b0000, 1'b0);
    for (int i = 0; i <= 4; i++) begin
      drive_phase(i);
      checks++;
      if (locked !== (i == 4)) begin
        failures++;
        $display("FAIL acquire_locked step=%0d got=%b want=%b", i, locked, (i == 4));
      end
    end
    checks++;
    if ({phase, phase_oh, valid, err, seq_err} !== {3'd4, 8'h10, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL acquire_phase got phase=%0d oh=%h valid=%b want phase=4 oh=10 valid=1",
               phase, phase_oh, valid);
    end
  endtask

  task automatic test_revolutions();
    int pulses = 0;
    for (int k = 0; k < 12; k++) begin
      drive_phase(5 + k);
      if (rev_pulse) pulses++;
      checks++;
      if ({rev_pulse, err, seq_err, locked} !== {((5 + k) % 8 == 0), 1'b0, 1'b0, 1'b1}) begin
        failures++;
        $display("FAIL rev_step k=%0d rev_pulse=%b err=%b seq_err=%b locked=%b", k, rev_pulse, err, seq_err, locked);
      end
    end
    checks++;
    if (pulses != 2 || rev_cnt !== 8'd2) begin
      failures++;
      $display("FAIL rev_count pulses=%0d rev_cnt=%0d want 2/2", pulses, rev_cnt);
    end
  endtask

  task automatic test_skip();
    drive_phase(1);
    drive_phase(2);
    checks++;
    if (locked !== 1'b1) begin
      failures++;
      $display("FAIL skip_pre_locked got=%b want=1", locked);
    end
    drive(4'b1111, 1'b1);
    checks++;
    if ({seq_err, err, locked, rev_pulse, rev_cnt} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'd2}) begin
      failures++;
      $display("FAIL skip_locked seq_err=%b err=%b locked=%b rev_pulse=%b rev_cnt=%0d want 1/0/0/0/2",
               seq_err, err, locked, rev_pulse, rev_cnt);
    end
    drive(4'b1111, 1'b1);
    checks++;
    if ({seq_err, err, locked} !== 3'b000) begin
      failures++;
      $display("FAIL skip_after got=%b want=000", {seq_err, err, locked});
    end
  endtask

  task automatic test_hold_acquire();
    drive(4'b0000, 1'b0);
    for (int i = 0; i <= 3; i++) drive_phase(i);
    for (int i = 0; i < 10; i++) begin
      drive_phase(3);
      checks++;
      if ({err, seq_err, locked, valid, phase} !== {1'b0, 1'b0, 1'b0, 1'b1, 3'd3}) begin
        failures++;
        $display("FAIL hold_acquire cyc=%0d err=%b seq_err=%b locked=%b valid=%b phase=%0d",
                 i, err, seq_err, locked, valid, phase);
      end
    end
    drive_phase(4);
    checks++;
    if ({locked, err, seq_err} !== 3'b100) begin
      failures++;
      $display("FAIL hold_then_lock got=%b want=100", {locked, err, seq_err});
    end
  endtask

  task automatic test_lock_on_wrap();
    drive(4'b0000, 1'b0);
    for (int p = 4; p <= 8; p++) drive_phase(p);
    checks++;
    if ({locked, rev_pulse, rev_cnt, phase} !== {1'b1, 1'b0, 8'd0, 3'd0}) begin
      failures++;
      $display("FAIL lock_on_wrap locked=%b rev_pulse=%b rev_cnt=%0d phase=%0d want 1/0/0/0",
               locked, rev_pulse, rev_cnt, phase);
    end
    for (int p = 1; p <= 8; p++) drive_phase(p);
    checks++;
    if ({rev_pulse, rev_cnt} !== {1'b1, 8'd1}) begin
      failures++;
      $display("FAIL first_rev_after_lock rev_pulse=%b rev_cnt=%0d want 1/1", rev_pulse, rev_cnt);
    end
  endtask

  task automatic test_wrap_and_reset();
    drive(4'b0000, 1'b0);
    for (int p = 0; p <= 4; p++) drive_phase(p);
    for (int k = 0; k < 36; k++) drive_phase(5 + k);
    checks++;
    if (rev_cnt2 !== 2'd1 || rev_cnt !== 8'd5) begin
      failures++;
      $display("FAIL rev_wrap rev_cnt2=%0d rev_cnt=%0d want 1/5", rev_cnt2, rev_cnt);
    end
    for (int p = 1; p <= 3; p++) drive_phase(p);
    drive(RING[4], 1'b0);
    checks++;
    if (got_vec() !== 24'h0 || {phase_oh2, valid2, locked2, rev_cnt2} !== 12'h0) begin
      failures++;
      $display("FAIL midring_reset got=%h w2=%h want all zero", got_vec(), {phase_oh2, valid2, locked2, rev_cnt2});
    end
    drive_phase(4);
    for (int k = 1; k <= LOCK_N; k++) begin
      drive_phase(4 + k);
      checks++;
      if ({locked, locked2, rev_pulse} !== {(k == LOCK_N), (k == LOCK_N), 1'b0}) begin
        failures++;
        $display("FAIL reacquire adv=%0d locked=%b locked2=%b rev_pulse=%b", k, locked, locked2, rev_pulse);
      end
    end
  endtask

  task automatic test_random();
    int r;
    drive(4'b0000, 1'b0);
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 70)      drive_phase(m_prev + 1);
      else if (r < 82) drive_phase(m_prev);
      else if (r < 97) drive(4'($urandom_range(0, 15)), 1'b1);
      else             drive(4'($urandom_range(0, 15)), 1'b0);
      checks++;
      if (got_vec() !== exp_vec() || rev_cnt2 !== 2'(m_rev)) begin
        failures++;
        $display("FAIL random cyc=%0d q=%b got=%h want=%h rev_cnt2=%0d want=%0d",
                 i, q, got_vec(), exp_vec(), rev_cnt2, 2'(m_rev));
      end
      checks++;
      if ((err && seq_err) || (rev_pulse && (err || seq_err))) begin
        failures++;
        $display("FAIL pulse_exclusive cyc=%0d err=%b seq_err=%b rev_pulse=%b", i, err, seq_err, rev_pulse);
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    q   = 4'b0000;
    m_mode = 0; m_run = 0; m_prev = 0; m_rev = 0;
    m_valid = 0; m_err = 0; m_seq = 0; m_revp = 0;
    @(negedge clk);
    test_reset();
    test_illegal_stuck();
    test_acquire();
    test_revolutions();
    test_skip();
    test_hold_acquire();
    test_lock_on_wrap();
    test_wrap_and_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
